spi_flash_reader: RTL

SPI read initiator for the user project: accepts a 24-bit flash address and a byte count, issues a standard `0x03` READ command on a single-bit SPI bus (mode 0), and streams the returned bytes out through a valid/ready port. It is the master-side counterpart of the `spiflash` behavioural model the Caravel benches already instantiate. It lets user-area logic, such as the AES datapath, fetch key, IV and test-vector tables straight from an external flash on `mprj_io` without firmware copying the data.

---
 rtl/spi_flash_reader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/spi_flash_reader.sv
// SPI mode-0 READ (0x03) initiator: sends command + 24-bit address, then streams req_len+1 bytes.
// Handshakes: a transfer happens on a clock edge where valid & ready are both 1; valid never waits on ready.
module spi_flash_reader #(
   parameter int DIV = 2
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [23:0] req_addr,
   input  logic [7:0]  req_len,
   output logic        data_valid,
   input  logic        data_ready,
   output logic [7:0]  data_out,
   output logic        done,
   output logic        flash_csb,
   output logic        flash_clk,
   output logic        flash_io0,
   input  logic        flash_io1,
   output logic [2:0]  fsm_state
);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, TAIL, GAP} state_t;

   localparam logic [7:0] DIV_M1   = 8'(DIV - 1);
   localparam logic [7:0] READ_CMD = 8'h03;

   state_t      state;
   logic [7:0]  cnt;
   logic [4:0]  bit_cnt;
   logic [8:0]  bytes_left;
   logic [31:0] tx_sr;
   logic [7:0]  rx_sr;
   logic        rose;
   logic        hold;
   logic        last_bit;
   logic        out_full;

   assign req_ready = (state == IDLE);
   assign fsm_state = state;
   assign out_full  = data_valid && !data_ready;

   always_comb begin
      last_bit = 1'b0;
      case (state)
         CMD, DATA: last_bit = (bit_cnt == 5'd7);
         ADDR:      last_bit = (bit_cnt == 5'd23);
         default:   last_bit = 1'b0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         bit_cnt    <= 5'd0;
         bytes_left <= 9'd0;
         tx_sr      <= 32'd0;
         rx_sr      <= 8'd0;
         rose       <= 1'b0;
         hold       <= 1'b0;
         data_valid <= 1'b0;
         data_out   <= 8'd0;
         done       <= 1'b0;
         flash_csb  <= 1'b1;
         flash_clk  <= 1'b0;
         flash_io0  <= 1'b0;
      end else begin
         done <= 1'b0;
         rose <= 1'b0;
         if (data_valid && data_ready) data_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state      <= CMD;
                  flash_csb  <= 1'b0;
                  tx_sr      <= {READ_CMD, req_addr};
                  flash_io0  <= READ_CMD[7];
                  cnt        <= DIV_M1;
                  bit_cnt    <= 5'd0;
                  bytes_left <= {1'b0, req_len} + 9'd1;
                  hold       <= 1'b0;
               end
            end
            CMD, ADDR, DATA: begin
               if (hold) begin
                  // Deferred 8th edge: restart a full half-period once the output register drains.
                  if (data_valid && data_ready) begin
                     hold <= 1'b0;
                     cnt  <= DIV_M1;
                  end
               end else if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else begin
                  cnt <= DIV_M1;
                  if (!flash_clk) begin
                     if (state == DATA && last_bit && out_full) begin
                        hold <= 1'b1;
                     end else begin
                        flash_clk <= 1'b1;
                        rose      <= 1'b1;
                     end
                  end else begin
                     flash_clk <= 1'b0;
                     tx_sr     <= {tx_sr[30:0], 1'b0};
                     flash_io0 <= (state == DATA) ? 1'b0 : tx_sr[30];
                     bit_cnt   <= bit_cnt + 5'd1;
                     if (last_bit) begin
                        bit_cnt <= 5'd0;
                        if (state == CMD) begin
                           state <= ADDR;
                        end else if (state == ADDR) begin
                           state     <= DATA;
                           flash_io0 <= 1'b0;
                        end else if (bytes_left == 9'd1) begin
                           state <= TAIL;
                        end else begin
                           bytes_left <= bytes_left - 9'd1;
                        end
                     end
                  end
               end
               // MISO is sampled at the end of the first SCK-high cycle.
               if (rose) begin
                  rx_sr <= {rx_sr[6:0], flash_io1};
                  if (state == DATA && last_bit) begin
                     data_out   <= {rx_sr[6:0], flash_io1};
                     data_valid <= 1'b1;
                  end
               end
            end
            TAIL: begin
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else begin
                  flash_csb <= 1'b1;
                  state     <= GAP;
                  cnt       <= DIV_M1;
               end
            end
            GAP: begin
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else if (!data_valid || data_ready) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
